case_1_sdiv_7s_6s_6_seq: RTL

// - Sequential signed divider. It is the inverse companion of the signed multiplier cores in the case_1 datapath.
// - Computes quot = din0 / din1 and rem = din0 % din1 with C semantics:

---
 rtl/case_1_sdiv_pkg.sv | 29 ++
 rtl/case_1_sdiv_abs.sv | 22 ++
 rtl/case_1_sdiv_7s_6s_6_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/case_1_sdiv_pkg.sv
// Shared types and constants for the case_1 sequential signed divider.
package case_1_sdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } sdiv_state_t;

    // Quotient reported when the divisor is zero (truncated by the user).
    localparam logic [31:0] DBZ_QUOT = '1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 32'sd0;
        v = value - 32'sd1;
        while (v > 32'sd0) begin
            r = r + 32'sd1;
            v = v >>> 1;
        end
        if (r < 32'sd1) begin
            r = 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/case_1_sdiv_abs.sv
// Combinational sign-magnitude split of a two's complement value.
module case_1_sdiv_abs
    import case_1_sdiv_pkg::*;
#(
    parameter int W = 7
) (
    input  logic [W-1:0] din,
    output logic [W:0]   mag,
    output logic         neg
);

    // One extra magnitude bit so the most negative input does not alias.
    always_comb begin
        neg = din[W-1];
        if (din[W-1]) begin
            mag = {(W+1){1'b0}} - {din[W-1], din};
        end else begin
            mag = {1'b0, din};
        end
    end

endmodule

// File: rtl/case_1_sdiv_7s_6s_6_seq.sv
// Radix-2 restoring signed divider with ap_start/ap_done handshake;
// C semantics: quotient truncates toward zero, remainder follows the dividend.
module case_1_sdiv_7s_6s_6_seq
    import case_1_sdiv_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 9,
    parameter int din0_WIDTH = 7,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 6
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_idle,
    output logic                  ap_ready,
    output logic                  ap_done,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_by_zero
);

    localparam int W0    = din0_WIDTH;
    localparam int W1    = din1_WIDTH;
    localparam int DW    = dout_WIDTH;
    localparam int CNT_W = clog2(W0);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(W0 - 32'sd1);

    generate
        if (ID < 32'sd0 || NUM_STAGE != W0 + 32'sd2) begin : g_bad_cfg
            $error("case_1_sdiv: NUM_STAGE must equal din0_WIDTH+2 and ID must be non-negative");
        end
    endgenerate

    sdiv_state_t       state_r;
    sdiv_state_t       state_s;

    logic [W0:0]       mag0_s;
    logic              neg0_s;
    logic [W1:0]       mag1_s;
    logic              neg1_s;

    logic [CNT_W-1:0]  cnt_r;
    logic [W0-1:0]     dvd_r;
    logic [W1:0]       dvs_r;
    logic [W1:0]       part_r;
    logic [W0-1:0]     q_r;
    logic              neg0_r;
    logic              neg1_r;
    logic              dbz_pend_r;
    logic [W1-1:0]     din0_lo_r;

    logic [DW-1:0]     quot_r;
    logic [W1-1:0]     rem_r;
    logic              dbz_r;

    logic [W1+1:0]     trial_s;
    logic              ge_s;
    logic [W1:0]       part_nxt_s;
    logic [DW-1:0]     q_mag_s;
    logic [DW-1:0]     quot_fix_s;
    logic [W1-1:0]     rem_fix_s;

    case_1_sdiv_abs #(.W(W0)) u_abs_din0 (
        .din (din0),
        .mag (mag0_s),
        .neg (neg0_s)
    );

    case_1_sdiv_abs #(.W(W1)) u_abs_din1 (
        .din (din1),
        .mag (mag1_s),
        .neg (neg1_s)
    );

    // State register.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: IDLE -> CALC -> FIX -> DONE -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (ap_start) begin
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX:     state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // One restoring step: partial is one bit wider than |divisor|, so no overflow.
    always_comb begin
        trial_s = {part_r, dvd_r[W0-1]};
        ge_s    = (trial_s >= {1'b0, dvs_r});
        if (ge_s) begin
            part_nxt_s = (W1+1)'(trial_s - {1'b0, dvs_r});
        end else begin
            part_nxt_s = trial_s[W1:0];
        end
    end

    // Sign fix and truncation of the final results; divide-by-zero overrides.
    always_comb begin
        q_mag_s = DW'(q_r);
        if (dbz_pend_r) begin
            quot_fix_s = DBZ_QUOT[DW-1:0];
            rem_fix_s  = din0_lo_r;
        end else begin
            if (neg0_r ^ neg1_r) begin
                quot_fix_s = {DW{1'b0}} - q_mag_s;
            end else begin
                quot_fix_s = q_mag_s;
            end
            if (neg0_r) begin
                rem_fix_s = {W1{1'b0}} - part_r[W1-1:0];
            end else begin
                rem_fix_s = part_r[W1-1:0];
            end
        end
    end

    // Operand capture, iteration datapath and output registers.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            cnt_r      <= CNT_ZERO;
            dvd_r      <= {W0{1'b0}};
            dvs_r      <= {(W1+1){1'b0}};
            part_r     <= {(W1+1){1'b0}};
            q_r        <= {W0{1'b0}};
            neg0_r     <= 1'b0;
            neg1_r     <= 1'b0;
            dbz_pend_r <= 1'b0;
            din0_lo_r  <= {W1{1'b0}};
            quot_r     <= {DW{1'b0}};
            rem_r      <= {W1{1'b0}};
            dbz_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ap_start) begin
                        // The top magnitude bit pre-seeds the partial remainder.
                        dvd_r      <= mag0_s[W0-1:0];
                        part_r     <= {{W1{1'b0}}, mag0_s[W0]};
                        dvs_r      <= mag1_s;
                        q_r        <= {W0{1'b0}};
                        neg0_r     <= neg0_s;
                        neg1_r     <= neg1_s;
                        dbz_pend_r <= (din1 == {W1{1'b0}});
                        din0_lo_r  <= W1'(din0);
                        cnt_r      <= CNT_INIT;
                    end
                end
                CALC: begin
                    part_r <= part_nxt_s;
                    dvd_r  <= {dvd_r[W0-2:0], 1'b0};
                    q_r    <= {q_r[W0-2:0], ge_s};
                    cnt_r  <= cnt_r - CNT_ONE;
                end
                FIX: begin
                    quot_r <= quot_fix_s;
                    rem_r  <= rem_fix_s;
                    dbz_r  <= dbz_pend_r;
                end
                DONE: begin
                    cnt_r <= CNT_ZERO;
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    assign ap_idle     = (state_r == IDLE);
    assign ap_ready    = (state_r == IDLE) && ap_start;
    assign ap_done     = (state_r == DONE);
    assign quot        = quot_r;
    assign rem         = rem_r;
    assign div_by_zero = dbz_r;

endmodule
